// File: rtl/kronos_mac_arb.sv
// kronos_mac_arb: shares one custom MAC unit between two requesters.
//
// The request channel uses round-robin arbitration. When the MAC applies backpressure, the grant
// is locked to the current requester. Each accepted request pushes its grantee into an in-order
// tag FIFO. The head of that FIFO routes each MAC response back to the requester that issued it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_req_valid/ready [1:0]       per-requester request handshake (bit i = requester i)
//   s_req_funct7 [13:0]           requester i operand fields at [7i+6:7i]
//   s_req_rs1/rs2 [63:0]          requester i operands at [32i+31:32i]
//   s_rsp_valid [1:0]             per-requester response valid
//   s_rsp_ready [1:0]             per-requester response ready
//   s_rsp_rd [31:0]               shared response data
//   m_req_*                       request channel to the MAC (granted requester's fields)
//   m_rsp_valid/ready, m_rsp_rd   response channel from the MAC
//
// Optional feature macro: KRONOS_MAC_ARB_PERF_EN
//   When defined, three saturating 16-bit counters are added as outputs:
//   perf_grant0, perf_grant1 and perf_full_stall.
//
// DEPTH must be a power of two and at least 2, so that the FIFO pointers wrap naturally.
module kronos_mac_arb #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  s_req_valid,
   output logic [1:0]  s_req_ready,
   input  logic [13:0] s_req_funct7,
   input  logic [63:0] s_req_rs1,
   input  logic [63:0] s_req_rs2,
   output logic [1:0]  s_rsp_valid,
   input  logic [1:0]  s_rsp_ready,
   output logic [31:0] s_rsp_rd,
   output logic        m_req_valid,
   input  logic        m_req_ready,
   output logic [6:0]  m_req_funct7,
   output logic [31:0] m_req_rs1,
   output logic [31:0] m_req_rs2,
   input  logic        m_rsp_valid,
   output logic        m_rsp_ready,
   input  logic [31:0] m_rsp_rd
`ifdef KRONOS_MAC_ARB_PERF_EN
   ,
   output logic [15:0] perf_grant0,
   output logic [15:0] perf_grant1,
   output logic [15:0] perf_full_stall
`endif
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   // ---------------------------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------------------------
   logic             rr_q, rr_d;
   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic [DEPTH-1:0] tag_q, tag_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   logic             g;
   logic             full;
   logic             empty;
   logic             head_tag;
   logic             req_hs;
   logic             rsp_hs;

   // ---------------------------------------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      g = rr_q;
      if (lock_q) begin
         // Hold the grant while a request is stalled, even if valid drops.
         g = lock_id_q;
      end else if (s_req_valid == 2'b11) begin
         g = rr_q;
      end else if (s_req_valid == 2'b01) begin
         g = 1'b0;
      end else if (s_req_valid == 2'b10) begin
         g = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Channel outputs
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      full     = (count_q == CntW'(DEPTH));
      empty    = (count_q == '0);
      head_tag = tag_q[rd_ptr_q];

      // Handshake outputs are held low throughout reset.
      m_req_valid    = !rst && s_req_valid[g] && !full;
      s_req_ready    = 2'b00;
      s_req_ready[g] = !rst && m_req_ready && !full;

      m_req_funct7 = g ? s_req_funct7[13:7] : s_req_funct7[6:0];
      m_req_rs1    = g ? s_req_rs1[63:32]   : s_req_rs1[31:0];
      m_req_rs2    = g ? s_req_rs2[63:32]   : s_req_rs2[31:0];

      s_rsp_valid           = 2'b00;
      s_rsp_valid[head_tag] = !rst && m_rsp_valid && !empty;
      m_rsp_ready           = !rst && !empty && s_rsp_ready[head_tag];
      s_rsp_rd              = m_rsp_rd;

      req_hs = m_req_valid && m_req_ready;
      rsp_hs = m_rsp_valid && m_rsp_ready;
   end

   // ---------------------------------------------------------------------------------------------
   // Next-state: arbitration, lock and tag FIFO
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      rr_d      = rr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      tag_d     = tag_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (req_hs) begin
         rr_d            = ~g;
         lock_d          = 1'b0;
         tag_d[wr_ptr_q] = g;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end else if (m_req_valid) begin
         lock_d    = 1'b1;
         lock_id_d = g;
      end

      if (rsp_hs) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      case ({req_hs, rsp_hs})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q      <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         tag_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         tag_q     <= tag_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

`ifdef KRONOS_MAC_ARB_PERF_EN
   // ---------------------------------------------------------------------------------------------
   // Saturating performance counters
   // ---------------------------------------------------------------------------------------------
   logic [15:0] perf_grant0_q, perf_grant0_d;
   logic [15:0] perf_grant1_q, perf_grant1_d;
   logic [15:0] perf_full_stall_q, perf_full_stall_d;

   always_comb begin
      perf_grant0_d     = perf_grant0_q;
      perf_grant1_d     = perf_grant1_q;
      perf_full_stall_d = perf_full_stall_q;
      if (req_hs && !g && (perf_grant0_q != 16'hFFFF)) begin
         perf_grant0_d = perf_grant0_q + 16'd1;
      end
      if (req_hs && g && (perf_grant1_q != 16'hFFFF)) begin
         perf_grant1_d = perf_grant1_q + 16'd1;
      end
      if ((|s_req_valid) && full && (perf_full_stall_q != 16'hFFFF)) begin
         perf_full_stall_d = perf_full_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_grant0_q     <= '0;
         perf_grant1_q     <= '0;
         perf_full_stall_q <= '0;
      end else begin
         perf_grant0_q     <= perf_grant0_d;
         perf_grant1_q     <= perf_grant1_d;
         perf_full_stall_q <= perf_full_stall_d;
      end
   end

   assign perf_grant0     = perf_grant0_q;
   assign perf_grant1     = perf_grant1_q;
   assign perf_full_stall = perf_full_stall_q;
`endif

endmodule

// File: doc/kronos_mac_arb.md
Name: kronos_mac_arb

Overview:
Arbiter that shares one custom MAC unit between two requesters, for example the EX stage and a second hart or accelerator master. Request channel: round-robin arbitration with grant lock under backpressure. An in-order tag FIFO records the grantee of each accepted request and routes each MAC response back to that requester. Sits between the requesters' MAC request/response channels and the single MAC unit.

Parameters:
DEPTH, 4, max outstanding requests accepted by the MAC but not yet answered; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_req_valid  in  2  per-requester request valid; bit i is requester i
s_req_ready  out  2  per-requester request ready
s_req_funct7  in  14  requester i uses bits [7i+6:7i]
s_req_rs1  in  64  requester i uses bits [32i+31:32i]
s_req_rs2  in  64  requester i uses bits [32i+31:32i]
s_rsp_valid  out  2  per-requester response valid
s_rsp_ready  in  2  per-requester response ready
s_rsp_rd  out  32  response data, shared by both requesters, qualified by s_rsp_valid
m_req_valid  out  1  request valid to MAC
m_req_ready  in  1  MAC accepts request
m_req_funct7  out  7  funct7 of the granted requester
m_req_rs1  out  32  rs1 of the granted requester
m_req_rs2  out  32  rs2 of the granted requester
m_rsp_valid  in  1  MAC response valid
m_rsp_ready  out  1  response accepted
m_rsp_rd  in  32  MAC response data

Behaviour:
- Reset (rst=1, async) clears:
  - rr pointer to 0, lock to 0, FIFO count and pointers to 0.
  - While rst=1, m_req_valid, s_req_ready, s_rsp_valid and m_rsp_ready are forced to 0.
- full = (count == DEPTH); empty = (count == 0). Both use registered count. No same-cycle pop bypass.
- Grant g (combinational):
  - Locked: g = lock_id.
  - Not locked: if both requesters are valid, g = rr; otherwise g = the single valid requester; with none valid, g = rr.
- Request outputs:
  - m_req_valid = s_req_valid[g] && !full.
  - m_req_funct7, m_req_rs1, m_req_rs2 = requester g's fields.
  - s_req_ready[g] = m_req_ready && !full; the other bit is 0.
- Request latency: zero-cycle combinational pass-through; no request registering.
- Lock:
  - If m_req_valid && !m_req_ready at a clock edge, then lock<=1 and lock_id<=g.
  - Lock clears on the request handshake.
  - Requesters hold valid and fields stable until ready. Dropping valid while locked is a protocol violation; lock is held regardless.
- Request handshake (m_req_valid && m_req_ready):
  - Push g into the tag FIFO.
  - rr <= the other requester (~g).
  - lock <= 0.
- Response path, with h = FIFO head tag:
  - s_rsp_valid[h] = m_rsp_valid && !empty; the other bit is 0.
  - m_rsp_ready = !empty && s_rsp_ready[h].
  - s_rsp_rd = m_rsp_rd.
  - Pop on m_rsp_valid && m_rsp_ready.
- m_rsp_valid while empty: m_rsp_ready stays 0 and the response is not acknowledged.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- Response ordering: the MAC answers strictly in request order, so tags pop in grant order.
- Reset mid-operation: outstanding tags are discarded; the MAC and requesters must be reset together.

Optional Feature:
KRONOS_MAC_ARB_PERF_EN
- Defined: adds three 16-bit output ports, each reset to 0 and saturating at 16'hFFFF.
  - perf_grant0: counts request handshakes with g=0.
  - perf_grant1: counts request handshakes with g=1.
  - perf_full_stall: counts cycles with |s_req_valid && full.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
1. Single requester: s0 issues 3 requests, m_req_ready=1; MAC returns rd=0x11, 0x22, 0x33 -> s_rsp_valid=2'b01 each time, s_rsp_rd matches in order, s_rsp_valid[1] never asserted.
2. Round-robin: both s_req_valid held 1 after reset, m_req_ready=1, responses popped every cycle -> grants 0,1,0,1,0,1 and each requester receives its own funct7/rs1/rs2 on m_req_*.
3. Lock: s1 valid, m_req_ready=0 for 3 cycles; s0 raises valid in cycle 2 -> m_req_* stays on s1 and s_req_ready[0]=0 until the s1 handshake; next grant goes to s0.
4. Full: DEPTH=4, 4 handshakes with no responses -> m_req_valid=0 and s_req_ready=2'b00. In the cycle a response pops, there is still no grant; grant resumes the next cycle.
5. Routing backpressure: grants s0 then s1; m_rsp_valid=1 with s_rsp_ready=2'b10 -> m_rsp_ready=0 until s_rsp_ready[0]=1. The first response goes to s0, the second to s1.
6. Reset mid-flight: 2 outstanding, pulse rst for 1 cycle -> count=0 and all handshake outputs 0. A later m_rsp_valid=1 gets m_rsp_ready=0; the next grant is requester 0.
